// File: rtl/pipelined_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pipelined_shifter                                                 |
// | Two-stage valid/ready ARM-style shifter (LSL/LSR/ASR/ROR/RRX, reg amounts).|
// | Optional imm8 rotate path enabled by macro SHIFTER_IMM_ROT_EN.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pipelined_shifter #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_type,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_by_reg,
  input  logic              in_imm_rot,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              busy
);
  localparam int LOG2W = $clog2(DATA_W);

  localparam logic [1:0] c_T_LSL = 2'd0;
  localparam logic [1:0] c_T_LSR = 2'd1;
  localparam logic [1:0] c_T_ASR = 2'd2;

  localparam logic [1:0] c_CS_CONST = 2'd0;
  localparam logic [1:0] c_CS_GUARD = 2'd1;
  localparam logic [1:0] c_CS_MSB   = 2'd2;

  localparam logic [LOG2W:0]   c_AMT_FULL = {1'b1, {LOG2W{1'b0}}};
  localparam logic [AMT_W-1:0] c_W_AMT    = AMT_W'(DATA_W);

  logic              r_s0_valid, r_s1_valid;
  logic [DATA_W-1:0] r_s0_data;
  logic              r_s0_rev, r_s0_fill, r_s0_rot, r_s0_cbit;
  logic [LOG2W:0]    r_s0_amt;
  logic [1:0]        r_s0_csel;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_carry;

  logic              w_s1_ready;
  logic [DATA_W-1:0] w_rev_in, w_res, w_res_rev, w_exe_data;
  logic              w_exe_carry;
  logic [DATA_W-1:0] w_d_data;
  logic              w_d_rev, w_d_fill, w_d_rot, w_d_cbit;
  logic [LOG2W:0]    w_d_amt, w_imm_amt, w_reg_amt;
  logic [1:0]        w_d_csel;
  logic              w_s, w_imm_zero, w_reg_over;

  assign w_s1_ready = !r_s1_valid || out_ready;
  assign in_ready   = !r_s0_valid || w_s1_ready;
  assign out_valid  = r_s1_valid;
  assign out_data   = r_out_data;
  assign out_carry  = r_out_carry;
  assign busy       = r_s0_valid || r_s1_valid;

`ifndef SHIFTER_IMM_ROT_EN
  logic w_unused_imm_rot;
  assign w_unused_imm_rot = in_imm_rot;
`endif

  // Left shifts run through the right-shift network on bit-reversed data.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign w_rev_in[i]  = in_data[DATA_W-1-i];
    assign w_res_rev[i] = w_res[DATA_W-1-i];
  end

  assign w_s        = in_data[DATA_W-1];
  assign w_imm_amt  = {1'b0, in_amt[LOG2W-1:0]};
  assign w_imm_zero = (in_amt[LOG2W-1:0] == '0);
  assign w_reg_amt  = (in_amt >= c_W_AMT) ? c_AMT_FULL : in_amt[LOG2W:0];
  assign w_reg_over = (in_amt > c_W_AMT);

  always_comb begin
    w_d_data = in_data;
    w_d_rev  = 1'b0;
    w_d_amt  = '0;
    w_d_fill = 1'b0;
    w_d_rot  = 1'b0;
    w_d_csel = c_CS_CONST;
    w_d_cbit = in_carry;
`ifdef SHIFTER_IMM_ROT_EN
    if (in_imm_rot) begin
      w_d_data = {{(DATA_W-8){1'b0}}, in_data[7:0]};
      w_d_rot  = 1'b1;
      w_d_amt  = {1'b0, in_amt[LOG2W-2:0], 1'b0};
      if (in_amt[LOG2W-2:0] != '0) w_d_csel = c_CS_MSB;
    end else
`endif
    if (!in_by_reg) begin
      case (in_type)
        c_T_LSL: begin
          w_d_data = w_rev_in;
          w_d_rev  = 1'b1;
          if (!w_imm_zero) begin
            w_d_amt  = w_imm_amt;
            w_d_csel = c_CS_GUARD;
          end
        end
        c_T_LSR, c_T_ASR: begin
          w_d_fill = (in_type == c_T_ASR) && w_s;
          w_d_amt  = w_imm_zero ? c_AMT_FULL : w_imm_amt;
          w_d_csel = c_CS_GUARD;
        end
        default: begin
          // Amount 0 encodes RRX: a one-bit right shift filling with the carry.
          if (w_imm_zero) begin
            w_d_amt  = (LOG2W+1)'(1);
            w_d_fill = in_carry;
            w_d_csel = c_CS_GUARD;
          end else begin
            w_d_rot  = 1'b1;
            w_d_amt  = w_imm_amt;
            w_d_csel = c_CS_MSB;
          end
        end
      endcase
    end else if (in_amt != '0) begin
      case (in_type)
        c_T_LSL, c_T_LSR: begin
          if (in_type == c_T_LSL) begin
            w_d_data = w_rev_in;
            w_d_rev  = 1'b1;
          end
          w_d_amt = w_reg_amt;
          if (w_reg_over) w_d_cbit = 1'b0;
          else            w_d_csel = c_CS_GUARD;
        end
        c_T_ASR: begin
          w_d_fill = w_s;
          w_d_amt  = w_reg_amt;
          w_d_csel = c_CS_GUARD;
        end
        default: begin
          if (w_imm_zero) begin
            w_d_cbit = w_s;
          end else begin
            w_d_rot  = 1'b1;
            w_d_amt  = w_imm_amt;
            w_d_csel = c_CS_MSB;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_data  <= '0;
      r_s0_rev   <= 1'b0;
      r_s0_amt   <= '0;
      r_s0_fill  <= 1'b0;
      r_s0_rot   <= 1'b0;
      r_s0_csel  <= c_CS_CONST;
      r_s0_cbit  <= 1'b0;
    end else if (in_ready) begin
      r_s0_valid <= in_valid;
      if (in_valid) begin
        r_s0_data <= w_d_data;
        r_s0_rev  <= w_d_rev;
        r_s0_amt  <= w_d_amt;
        r_s0_fill <= w_d_fill;
        r_s0_rot  <= w_d_rot;
        r_s0_csel <= w_d_csel;
        r_s0_cbit <= w_d_cbit;
      end
    end
  end

  // Bit 0 of each level is a guard that catches the last bit shifted out.
  logic [DATA_W:0] w_lvl [LOG2W+2];
  assign w_lvl[0] = {r_s0_data, 1'b0};

  for (genvar k = 0; k <= LOG2W; k++) begin : g_lvl
    localparam int c_S = 1 << k;
    if (k < LOG2W) begin : g_part
      assign w_lvl[k+1] = !r_s0_amt[k] ? w_lvl[k] :
                          r_s0_rot ? {w_lvl[k][c_S:1], w_lvl[k][DATA_W:c_S+1], w_lvl[k][0]} :
                                     {{c_S{r_s0_fill}}, w_lvl[k][DATA_W:c_S]};
    end else begin : g_full
      assign w_lvl[k+1] = (!r_s0_amt[k] || r_s0_rot) ? w_lvl[k] :
                          {{DATA_W{r_s0_fill}}, w_lvl[k][DATA_W]};
    end
  end

  assign w_res      = w_lvl[LOG2W+1][DATA_W:1];
  assign w_exe_data = r_s0_rev ? w_res_rev : w_res;

  always_comb begin
    w_exe_carry = r_s0_cbit;
    case (r_s0_csel)
      c_CS_GUARD: w_exe_carry = w_lvl[LOG2W+1][0];
      c_CS_MSB:   w_exe_carry = w_res[DATA_W-1];
      default:    w_exe_carry = r_s0_cbit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_out_data  <= w_exe_data;
        r_out_carry <= w_exe_carry;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pipelined_shifter                                              |
// | Self-checking bench for pipelined_shifter (W=32), honours SHIFTER_IMM_ROT_EN|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pipelined_shifter;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_by_reg, in_imm_rot, in_carry;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_type;
  logic [7:0]  in_amt;
  logic        out_valid, out_ready, out_carry, busy;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  logic [32:0] exp_q[$];

  pipelined_shifter #(.DATA_W(32), .AMT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_type(in_type), .in_amt(in_amt), .in_by_reg(in_by_reg),
    .in_imm_rot(in_imm_rot), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror32(input logic [31:0] d, input int n);
    logic [63:0] x;
    x = {d, d} >> n;
    return x[31:0];
  endfunction

  // Reference: ARM shifter operand rules written out directly.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [1:0] t,
                                        input logic [7:0] amt, input logic br,
                                        input logic ir, input logic cin);
    logic [31:0] r;
    logic        c;
    int          a, n;
    logic [63:0] sx;
    logic [63:0] zx;
    sx = {{32{d[31]}}, d};
    zx = {32'd0, d};
    r = d;
    c = cin;
`ifdef SHIFTER_IMM_ROT_EN
    if (ir) begin
      n = 2 * int'(amt[3:0]);
      r = ror32({24'd0, d[7:0]}, n);
      c = (n == 0) ? cin : r[31];
      return {c, r};
    end
`else
    begin
      logic unused_ir;
      unused_ir = ir;
    end
`endif
    if (!br) begin
      a = int'(amt[4:0]);
      n = (a == 0) ? 32 : a;
      case (t)
        2'd0: if (a != 0) begin r = d << a; c = d[32-a]; end
        2'd1: begin zx = zx >> n; r = zx[31:0]; c = d[n-1]; end
        2'd2: begin sx = sx >> n; r = sx[31:0]; c = d[n-1]; end
        default: if (a == 0) begin r = {cin, d[31:1]}; c = d[0]; end
                 else begin r = ror32(d, a); c = d[a-1]; end
      endcase
    end else begin
      a = int'(amt);
      if (a != 0) begin
        case (t)
          2'd0: if (a < 32) begin r = d << a; c = d[32-a]; end
                else if (a == 32) begin r = 0; c = d[0]; end
                else begin r = 0; c = 0; end
          2'd1: if (a < 32) begin r = d >> a; c = d[a-1]; end
                else if (a == 32) begin r = 0; c = d[31]; end
                else begin r = 0; c = 0; end
          2'd2: if (a < 32) begin sx = sx >> a; r = sx[31:0]; c = d[a-1]; end
                else begin r = {32{d[31]}}; c = d[31]; end
          default: begin
            n = a % 32;
            if (n == 0) begin r = d; c = d[31]; end
            else begin r = ror32(d, n); c = d[n-1]; end
          end
        endcase
      end
    end
    return {c, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [31:0] d, input logic [1:0] t, input logic [7:0] amt,
                      input logic br, input logic ir, input logic cin);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_type = t; in_amt = amt;
    in_by_reg = br; in_imm_rot = ir; in_carry = cin;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_50");
    end else begin
      n_acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [31:0] d, input logic [1:0] t,
                     input logic [7:0] amt, input logic br, input logic ir, input logic cin,
                     input logic [31:0] ed, input logic ec);
    chk({nm, "_model"}, 64'(model(d, t, amt, br, ir, cin)), 64'({ec, ed}));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(d, t, amt, br, ir, cin);
    @(negedge clk);
    chk({nm, "_lat1"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'(1));
    chk({nm, "_data"}, 64'(out_data), 64'(ed));
    chk({nm, "_carry"}, 64'(out_carry), 64'(ec));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 64'(busy), 64'(0));
  endtask

  // Scoreboard and stall-stability compare, sampled on the falling edge.
  initial begin
    logic        hold_pend;
    logic [32:0] held, e;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (hold_pend) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_hold", 64'({out_carry, out_data}), 64'(held));
      end
      hold_pend = out_valid && !out_ready && !rst;
      held = {out_carry, out_data};
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_out actual=valid_output required=no_output");
          end else begin
            e = exp_q.pop_front();
            if ({out_carry, out_data} !== e) begin
              errors++;
              $display("FAIL result actual=%h required=%h", {out_carry, out_data}, e);
            end
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(in_data, in_type, in_amt, in_by_reg, in_imm_rot, in_carry));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int amts[8];
    logic [31:0] bd;
    amts = '{0, 1, 5, 16, 31, 32, 33, 200};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_type = '0; in_amt = '0;
    in_by_reg = 1'b0; in_imm_rot = 1'b0; in_carry = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_carry", 64'(out_carry), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    lit("lsl_imm4", 32'h8000_000F, 2'd0, 8'd4, 1'b0, 1'b0, 1'b1, 32'h0000_00F0, 1'b0);
    lit("lsr_imm0", 32'h8000_0001, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    lit("rrx", 32'h0000_0003, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 1'b1);
    lit("lsr_imm8", 32'h1234_5680, 2'd1, 8'd8, 1'b0, 1'b0, 1'b0, 32'h0012_3456, 1'b1);
    lit("ror_imm4", 32'h0000_001F, 2'd3, 8'd4, 1'b0, 1'b0, 1'b0, 32'hF000_0001, 1'b1);
    lit("asr_reg40", 32'h8000_0000, 2'd2, 8'd40, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    lit("asr_reg0", 32'h1234_5678, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
    lit("lsl_reg32", 32'h0000_0001, 2'd0, 8'd32, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    lit("lsl_reg33", 32'h0000_0001, 2'd0, 8'd33, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    lit("lsr_reg32", 32'h8000_0000, 2'd1, 8'd32, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    lit("ror_reg64", 32'h8000_0000, 2'd3, 8'd64, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
`ifdef SHIFTER_IMM_ROT_EN
    lit("imm_rot", 32'h0000_00FF, 2'd0, 8'd4, 1'b0, 1'b1, 1'b0, 32'hFF00_0000, 1'b1);
`else
    lit("imm_rot_off", 32'h0000_00FF, 2'd0, 8'd4, 1'b0, 1'b1, 1'b0, 32'h0000_0FF0, 1'b0);
`endif
    drain();

    // Backpressure: four back-to-back ops against a stalled consumer.
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send(32'hDEAD_BEEF, 2'd0, 8'd3, 1'b0, 1'b0, 1'b0);
        send(32'h8765_4321, 2'd2, 8'd7, 1'b0, 1'b0, 1'b1);
        send(32'h0F0F_00F0, 2'd3, 8'd12, 1'b1, 1'b0, 1'b0);
        send(32'hCAFE_F00D, 2'd1, 8'd33, 1'b1, 1'b0, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts", 64'(n_acc), 64'(2));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Directed burst with intermittent consumer stalls.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          bd = (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h0F0F_0F0F;
          send(bd, 2'(i % 4), 8'(amts[i % 8]), 1'((i / 4) % 2), 1'(i % 5 == 4), 1'(i % 3 == 1));
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = ((c % 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a stall discards in-flight work.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h1111_2222, 2'd1, 8'd4, 1'b0, 1'b0, 1'b0);
    send(32'h3333_4444, 2'd0, 8'd4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall_out_valid", 64'(out_valid), 64'(0));
    chk("rst_stall_busy", 64'(busy), 64'(0));
    chk("rst_stall_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    lit("post_rst", 32'h0000_0081, 2'd3, 8'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0040, 1'b1);
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, two-stage pipelined shift unit for the data-processing operand path. It produces an ARM-style shifter operand and shifter carry for any power-of-two data width. Supported operations are LSL, LSR, ASR, ROR, RRX, register-specified amounts and 8-bit-immediate rotation. A valid/ready handshake on both sides lets it sit between decode and the ALU under backpressure, with throughput of one operation per cycle.

## Interface
- `DATA_W`, 32: operand width W; power of two, at least 8. `LOG2W` = log2(W) is derived.
- `AMT_W`, 8: width of the register-specified shift amount; must satisfy AMT_W > LOG2W.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: input operation valid.
- `in_ready` out 1: unit can accept an operation this cycle.
- `in_data` in W: Rm value, or imm8 in [7:0] when `in_imm_rot`=1.
- `in_type` in 2: 0 LSL, 1 LSR, 2 ASR, 3 ROR.
- `in_amt` in AMT_W: shift amount (usage below).
- `in_by_reg` in 1: amount taken from a register (Rs[7:0]).
- `in_imm_rot` in 1: 32-bit-immediate rotate mode.
- `in_carry` in 1: current C flag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out W: shifter operand.
- `out_carry` out 1: shifter carry out.
- `busy` out 1: at least one pipeline stage holds a valid operation.

## Operation
Notation: a = amount, cin = `in_carry`, s = `in_data[W-1]`.

- **Priority:** `in_imm_rot` overrides `in_by_reg` and `in_type`.
- **Immediate-rotate mode (`in_imm_rot`=1):**
  - Rotation r = 2·`in_amt[LOG2W-2:0]`.
  - Result = ROR(zero-extended `in_data[7:0]`, r).
  - Carry = cin if r=0, otherwise result[W-1].
- **Immediate amount (`in_by_reg`=0):** a = `in_amt[LOG2W-1:0]`.
  - LSL: a=0 gives data, cin. Otherwise data<<a, carry data[W-a].
  - LSR: a=0 encodes a shift of W, giving 0, carry s. Otherwise data>>a, carry data[a-1].
  - ASR: a=0 encodes a shift of W, giving all bits = s, carry s. Otherwise arithmetic >>a, carry data[a-1].
  - ROR: a=0 is RRX, giving {cin, data[W-1:1]}, carry data[0]. Otherwise rotate by a, carry data[a-1].
- **Register amount (`in_by_reg`=1):** a = full `in_amt`. For a=0, every type gives data, cin.
  - LSL: a<W gives data<<a, carry data[W-a]. a=W gives 0, carry data[0]. a>W gives 0, carry 0.
  - LSR: a<W gives data>>a, carry data[a-1]. a=W gives 0, carry s. a>W gives 0, carry 0.
  - ASR: a<W gives arithmetic shift, carry data[a-1]. a≥W gives all bits = s, carry s.
  - ROR: m = a mod W. m=0 gives data, carry s. Otherwise rotate by m, carry data[m-1].
- **Totality:** every input combination yields a defined result. There is no hold-previous behaviour and no latch.
- **Stage 0 (decode):**
  - Captures the operation on `in_valid && in_ready`.
  - Registers the normalised form: direction, effective amount 0..W, fill bit, rotate flag, carry-select.
- **Stage 1 (execute):** registers `out_data` and `out_carry`, computed by a log2(W)-level mux network from the stage-0 registers.

## Timing
- **Latency:** 2 cycles from input handshake to `out_valid` when `out_ready` is held high.
- **Throughput:** one operation per cycle.
- **Stage advance:** each stage advances when its successor is empty or is draining in the same cycle.
  - `in_ready` = !s0_valid || (s1 empty or `out_ready`).
  - `in_ready` is combinational from `out_ready`; there is no combinational path from `in_*` to `out_*`.
- **Stall:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_carry` and `out_valid` hold stable.
  - Stage 0 holds if it is full.
  - At most 2 operations are in flight.
- **Simultaneous accept and drain:** both happen in the same cycle with no bubble.
- **Reset:** `rst`=1 at an edge clears both stage valids.
  - After reset: `out_valid`=0, `out_data`=0, `out_carry`=0, `busy`=0.
  - `in_ready`=1 in the first cycle after reset is released.
  - In-flight operations are discarded, including during a stall.
- **Ordering:** results leave in acceptance order; operations are never dropped or duplicated.

## Configuration
- **`SHIFTER_IMM_ROT_EN` defined:** immediate-rotate mode operates as specified.
- **`SHIFTER_IMM_ROT_EN` undefined:**
  - The `in_imm_rot` port remains and is ignored; it is treated as 0.
  - The imm8 rotate path is not synthesised.
  - All other behaviour is unchanged.

## Test plan
All scenarios use W=32.
- **LSL immediate:** imm LSL a=4, data 0x8000_000F, cin=1 → out 0x0000_00F0, carry 0. Result appears 2 cycles after the handshake.
- **LSR and RRX encodings:** imm LSR a=0, data 0x8000_0001 → 0x0000_0000, carry 1. Imm ROR a=0, data 0x0000_0003, cin=1 → 0x8000_0001, carry 1.
- **Register ASR:** ASR by reg a=40, data 0x8000_0000 → 0xFFFF_FFFF, carry 1. ASR by reg a=0, cin=0 → data unchanged, carry 0.
- **Register LSL/ROR edges:** LSL by reg a=32, data 0x0000_0001 → 0, carry 1. LSL by reg a=33 → 0, carry 0. ROR by reg a=64, data 0x8000_0000 → 0x8000_0000, carry 1.
- **Immediate rotate (macro on):** imm_rot, `in_amt`=4, imm8 0xFF → 0xFF00_0000, carry 1. With the macro off, the same stimulus → LSL/LSR result per `in_type`.
- **Backpressure and reset:**
  - Stimulus: 4 back-to-back ops with `out_ready`=0 for 5 cycles. Required: `in_ready` falls after 2 accepts, outputs stay stable, and all 4 results appear in order once `out_ready`=1.
  - Stimulus: `rst` asserted during the stall. Required: `out_valid`=0 and `busy`=0 the next cycle.
